// File: rtl/run_limit_pkg.sv
// Shared definitions for the run-length-limited serial transmitter.
// The state encoding is one-hot so the debug port can expose it directly.
package run_limit_pkg;

    typedef enum logic [3:0] {
        IDLE  = 4'b0001,
        START = 4'b0010,
        DATA  = 4'b0100,
        STUFF = 4'b1000
    } state_t;

    localparam int DATA_W_DEF  = 8;
    localparam int MAX_RUN_DEF = 3;

endpackage

// File: rtl/run_limit_tx.sv
// Serial frame transmitter with run-length limiting.
// A captured word is sent as a start bit (0) followed by the payload, MSB first.
// Whenever MAX_RUN equal bits have gone out in a row, the opposite bit is
// inserted so the receiver always sees transitions. The start bit counts
// toward the first run. A stuff bit owed after the last payload bit is still
// sent before the line returns to idle (1).
module run_limit_tx
    import run_limit_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int MAX_RUN = MAX_RUN_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              sout,
    output logic              busy,
    output logic              frame_done,
    output logic [3:0]        state
);

    localparam int               CNT_W     = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] BITS_FULL = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = '0;
    localparam logic [2:0]       RUN_LIMIT = 3'(MAX_RUN);

    state_t            state_q;
    state_t            state_d;
    logic [DATA_W-1:0] shift_q;
    logic [DATA_W-1:0] shift_d;
    logic [CNT_W-1:0]  bit_cnt_q;
    logic [CNT_W-1:0]  bit_cnt_d;
    logic              run_bit_q;
    logic              run_bit_d;
    logic [2:0]        run_cnt_q;
    logic [2:0]        run_cnt_d;

    logic              data_bit;
    logic [2:0]        run_cnt_upd;

    // The bit currently on the line in DATA, and what the run length becomes
    // once that bit has been sent.
    assign data_bit    = shift_q[DATA_W-1];
    assign run_cnt_upd = (data_bit == run_bit_q) ? (run_cnt_q + 3'd1) : 3'd1;

    assign busy  = (state_q != IDLE);
    assign state = state_q;

    // State, payload and run-tracking registers; reset drops any frame in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            run_bit_q <= 1'b1;
            run_cnt_q <= 3'd0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            run_bit_q <= run_bit_d;
            run_cnt_q <= run_cnt_d;
        end
    end

    // Next-state and output decode, all derived from the registered values.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        run_bit_d  = run_bit_q;
        run_cnt_d  = run_cnt_q;
        sout       = 1'b1;
        in_ready   = 1'b0;
        frame_done = 1'b0;

        case (state_q)
            IDLE: begin
                sout     = 1'b1;
                in_ready = 1'b1;
                if (in_valid) begin
                    shift_d   = in_data;
                    bit_cnt_d = BITS_FULL;
                    state_d   = START;
                end
            end

            START: begin
                sout      = 1'b0;
                run_bit_d = 1'b0;
                run_cnt_d = 3'd1;
                state_d   = DATA;
            end

            DATA: begin
                sout      = data_bit;
                shift_d   = {shift_q[DATA_W-2:0], 1'b0};
                bit_cnt_d = bit_cnt_q - CNT_ONE;
                run_bit_d = data_bit;
                run_cnt_d = run_cnt_upd;
                if (run_cnt_upd == RUN_LIMIT) begin
                    state_d = STUFF;
                end else if (bit_cnt_q == CNT_ONE) begin
                    state_d    = IDLE;
                    frame_done = 1'b1;
                end
            end

            STUFF: begin
                sout      = ~run_bit_q;
                run_bit_d = ~run_bit_q;
                run_cnt_d = 3'd1;
                if (bit_cnt_q == CNT_ZERO) begin
                    state_d    = IDLE;
                    frame_done = 1'b1;
                end else begin
                    state_d = DATA;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: doc/run_limit_tx.md
RUN_LIMIT_TX -- requirements
Module: run_limit_tx

Interface
REQ-001 SHALL have parameter DATA_W, default 8, payload width per frame (legal 4..16).
REQ-002 SHALL have parameter MAX_RUN, default 3, longest permitted run of equal serial bits (legal 2..7).
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  producer presents a word.
REQ-006 SHALL have port in_data  input  DATA_W  word to transmit, MSB first.
REQ-007 SHALL have port in_ready  output  1  block accepts a word this cycle.
REQ-008 SHALL have port sout  output  1  serial line, one bit per clk.
REQ-009 SHALL have port busy  output  1  frame in progress (any state but IDLE).
REQ-010 SHALL have port frame_done  output  1  single-cycle pulse on the last serial bit of a frame.
REQ-011 SHALL have port state  output  4  one-hot debug view {STUFF, DATA, START, IDLE}, bit0 = IDLE.

Function
REQ-012 SHALL implement an FSM with states IDLE, START, DATA, STUFF; all outputs Moore-decoded from registered state, shift register and counters.
REQ-013 IDLE: sout=1, in_ready=1; on in_valid=1, capture in_data into shift register, load bit counter with DATA_W, go to START.
REQ-014 START: sout=0 for exactly one cycle; set run_bit=0, run_cnt=1; go to DATA.
REQ-015 DATA: sout = shift register MSB; on the edge, shift left, decrement bit counter, and update run tracking: same bit as run_bit -> run_cnt+1, else run_bit=bit, run_cnt=1.
REQ-016 DATA: if updated run_cnt == MAX_RUN, go to STUFF; else if the bit counter reaches 0, go to IDLE; else stay in DATA.
REQ-017 STUFF: sout = ~run_bit for one cycle; set run_bit=~run_bit, run_cnt=1; go to DATA if bits remain, else IDLE.
REQ-018 A stuff bit triggered by the final data bit SHALL still be sent before IDLE.
REQ-019 Latency: handshake in cycle T -> start bit in T+1 -> data MSB in T+2.
REQ-020 Frame length SHALL be 1 + DATA_W + number of stuff bits; sout SHALL never carry more than MAX_RUN equal consecutive bits between START and the return to IDLE.
REQ-021 frame_done SHALL be 1 in the cycle whose state transitions to IDLE (last data bit or trailing stuff bit).
REQ-022 in_ready SHALL be 0 outside IDLE; in_valid/in_data outside IDLE SHALL be ignored and SHALL NOT corrupt the frame in flight.
REQ-023 Back-to-back words SHALL be separated by at least one IDLE cycle (sout=1).
REQ-024 run_cnt SHALL be 3 bits and SHALL never exceed MAX_RUN; bit counter SHALL be $clog2(DATA_W+1) bits.

Reset
REQ-025 rst=0 SHALL force IDLE immediately, independent of clk: sout=1, in_ready=1, busy=0, frame_done=0, state=4'b0001, shift register=0, counters=0, run_bit=1.
REQ-026 Reset asserted mid-frame SHALL abandon the frame with no trailing bits; the first post-reset word SHALL transmit as a complete fresh frame.
REQ-027 Release of rst SHALL be synchronous to clk; first handshake accepted on the first rising edge after release.

Structure
REQ-028 A shared package run_limit_pkg SHALL hold the state enum typedef (4-bit, IDLE/START/DATA/STUFF) and default constants DATA_W_DEF=8, MAX_RUN_DEF=3.
REQ-029 The block SHALL be a single module with no sub-modules; next-state logic in one combinational block, registers in one asynchronous-reset sequential block.

Verification
REQ-030 in_data=8'hA5 handshake -> sout 0,1,0,1,0,0,1,0,1 (9 cycles), frame_done on the 9th bit, no stuff bits.
REQ-031 in_data=8'h00 -> sout 0,0,0,1,0,0,0,1,0,0,0,1 (12 cycles incl. trailing stuff), then sout=1 in IDLE.
REQ-032 in_data=8'hFF -> sout 0,1,1,1,0,1,1,1,0,1,1 (11 cycles), frame_done on the 11th bit.
REQ-033 in_valid held high with 8'hA5 then 8'h3C -> second start bit exactly one IDLE cycle after first frame_done; in_data change mid-frame leaves the first frame unchanged.
REQ-034 rst pulsed low during the 5th data bit of 8'h00 -> outputs take reset values within the same cycle; next word 8'hA5 transmits exactly per REQ-030.
REQ-035 Random 10k words with MAX_RUN=2 and 3 -> scoreboard de-stuffs and matches the payload; no run longer than MAX_RUN between start bit and IDLE.
